// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial pattern detector.
//   MODE_NONOVL / MODE_OVL : encodings of the overlap-mode register
//   sat_inc()              : saturating increment for counters of any width
//                            up to SAT_MAX_W bits
package seq_det_pkg;

  localparam logic MODE_NONOVL = 1'b0;
  localparam logic MODE_OVL    = 1'b1;

  localparam int unsigned SAT_MAX_W = 32;

  // Increment cnt, holding at the all-ones value of a w-bit counter.
  // The caller zero-extends its value in and truncates the result back.
  function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] cnt,
                                                    input int unsigned        w);
    logic [SAT_MAX_W-1:0] max_v;
    // For w >= SAT_MAX_W the shift yields 0 and the subtraction gives all-ones.
    max_v = (SAT_MAX_W'(1) << w) - 1'b1;
    return (cnt == max_v) ? cnt : cnt + 1'b1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter.
//   clk   : rising-edge clock
//   rst   : synchronous active-high reset, clears the count
//   inc   : add one this cycle (ignored once at 2**W-1)
//   value : current count
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q, value_d;

  always_comb begin
    value_d = value_q;
    if (inc) value_d = W'(sat_inc(SAT_MAX_W'(value_q), W));
  end

  always_ff @(posedge clk) begin
    if (rst) value_q <= '0;
    else     value_q <= value_d;
  end

  assign value = value_q;

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial bit-pattern detector (Moore, registered outputs).
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   a         : serial data bit, sampled only when a_valid is high
//   a_valid   : qualifies a
//   pat_load  : load pat_in / ovl_en as the new pattern and mode; clears history
//   pat_in    : new pattern, MSB = oldest bit
//   ovl_en    : overlap mode captured with pat_load (1 = overlapping)
//   y         : one-cycle match pulse, one cycle after the completing bit
//   match_cnt : saturating count of matches since reset
//   pat_cur   : currently active pattern
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int unsigned      PAT_W   = 3,
  parameter logic [PAT_W-1:0] PATTERN = 3'b101,
  parameter logic             OVERLAP = 1'b0,
  parameter int unsigned      CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             a_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             ovl_en,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt,
  output logic [PAT_W-1:0] pat_cur
);

  localparam int unsigned           FILL_W   = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]     FILL_PAT = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              mode_q, mode_d;
  logic              y_q, y_d;

  logic [PAT_W-1:0]  hist_nxt;
  logic [FILL_W-1:0] fill_nxt;
  logic              match;

  always_comb begin
    hist_d   = hist_q;
    fill_d   = fill_q;
    pat_d    = pat_q;
    mode_d   = mode_q;
    hist_nxt = {hist_q[PAT_W-2:0], a};
    fill_nxt = (fill_q == FILL_PAT) ? fill_q : fill_q + 1'b1;
    match    = 1'b0;

    if (pat_load) begin
      // A bit arriving with the load is dropped; the new pattern starts clean.
      pat_d  = pat_in;
      mode_d = ovl_en;
      hist_d = '0;
      fill_d = '0;
    end else if (a_valid) begin
      // fill guards against the zeroed history matching an all-zero pattern.
      match  = (fill_nxt == FILL_PAT) && (hist_nxt == pat_q);
      hist_d = hist_nxt;
      fill_d = (match && (mode_q == MODE_NONOVL)) ? '0 : fill_nxt;
    end

    y_d = match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= PATTERN;
      mode_q <= OVERLAP;
      y_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      mode_q <= mode_d;
      y_q    <= y_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (match),
    .value (match_cnt)
  );

  assign y       = y_q;
  assign pat_cur = pat_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: two instances (default parameters, and a
// 2-bit-counter overlapping 111 variant) share one stimulus stream and are
// compared every cycle against a window-of-accepted-bits reference model.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       rst, a, a_valid, pat_load, ovl_en;
  logic [2:0] pat_in;

  logic       y0, y1;
  logic [7:0] cnt0;
  logic [1:0] cnt1;
  logic [2:0] pat0, pat1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_param dut0 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .pat_load(pat_load),
    .pat_in(pat_in), .ovl_en(ovl_en), .y(y0), .match_cnt(cnt0), .pat_cur(pat0)
  );

  seq_detect_param #(.PAT_W(3), .PATTERN(3'b111), .OVERLAP(1'b1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst), .a(a), .a_valid(a_valid), .pat_load(pat_load),
    .pat_in(pat_in), .ovl_en(ovl_en), .y(y1), .match_cnt(cnt1), .pat_cur(pat1)
  );

  // Reference model: per instance, the accepted bits since the last clear,
  // trimmed to the newest three; a match is "window full and equals pattern".
  bit         w0[$], w1[$];
  logic [2:0] m_pat[2];
  bit         m_ovl[2];
  bit         m_y[2];
  int         m_cnt[2];

  task automatic model_one(input int d, input bit r, input bit v, input bit av,
                           input bit pl, input logic [2:0] pi, input bit oe);
    bit         w[$];
    logic [2:0] last;
    int         cmax;
    cmax = (d == 0) ? 255 : 3;
    if (d == 0) w = w0; else w = w1;
    m_y[d] = 1'b0;
    if (r) begin
      w.delete();
      m_pat[d] = (d == 0) ? 3'b101 : 3'b111;
      m_ovl[d] = (d == 1);
      m_cnt[d] = 0;
    end else if (pl) begin
      w.delete();
      m_pat[d] = pi;
      m_ovl[d] = oe;
    end else if (v) begin
      w.push_back(av);
      if (w.size() > 3) void'(w.pop_front());
      if (w.size() == 3) begin
        last = {w[0], w[1], w[2]};
        if (last == m_pat[d]) begin
          m_y[d] = 1'b1;
          if (m_cnt[d] < cmax) m_cnt[d]++;
          if (!m_ovl[d]) w.delete();
        end
      end
    end
    if (d == 0) w0 = w; else w1 = w;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle, advance the model, compare both instances.
  task automatic step(input bit r, input bit v, input bit av, input bit pl,
                      input logic [2:0] pi, input bit oe);
    rst = r; a_valid = v; a = av; pat_load = pl; pat_in = pi; ovl_en = oe;
    @(posedge clk); #1;
    model_one(0, r, v, av, pl, pi, oe);
    model_one(1, r, v, av, pl, pi, oe);
    chk("y0",   {31'b0, y0},   {31'b0, m_y[0]});
    chk("cnt0", {24'b0, cnt0}, m_cnt[0]);
    chk("pat0", {29'b0, pat0}, {29'b0, m_pat[0]});
    chk("y1",   {31'b0, y1},   {31'b0, m_y[1]});
    chk("cnt1", {30'b0, cnt1}, m_cnt[1]);
    chk("pat1", {29'b0, pat1}, {29'b0, m_pat[1]});
  endtask

  task automatic bit_in(input bit av);
    step(1'b0, 1'b1, av, 1'b0, 3'b000, 1'b0);
  endtask

  task automatic gap(input bit av);
    step(1'b0, 1'b0, av, 1'b0, 3'b000, 1'b0);
  endtask

  initial begin
    rst = 1'b1; a = 1'b0; a_valid = 1'b0; pat_load = 1'b0; pat_in = '0; ovl_en = 1'b0;

    // reset state
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("rst_y0", {31'b0, y0}, 32'd0);
    chk("rst_pat0", {29'b0, pat0}, 32'h5);

    // 1: default non-overlap 101, stream 1,0,1,0,1
    bit_in(1); bit_in(0); bit_in(1);
    bit_in(0); bit_in(1);
    gap(0);
    chk("t1_cnt0", {24'b0, cnt0}, 32'd1);

    // 2: overlap 101, same stream
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b1);
    bit_in(1); bit_in(0); bit_in(1); bit_in(0); bit_in(1);
    gap(0);
    chk("t2_cnt0", {24'b0, cnt0}, 32'd3);

    // 3: valid gaps, gap bits carry a=1
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b101, 1'b0);
    bit_in(1); gap(1); gap(1); gap(1); bit_in(0); gap(1); bit_in(1);
    gap(1);

    // 4: load 110 with a simultaneous valid 1, then 1,1,0
    step(1'b0, 1'b1, 1'b1, 1'b1, 3'b110, 1'b0);
    bit_in(1); bit_in(1); bit_in(0);
    chk("t4_y0", {31'b0, y0}, 32'd1);
    chk("t4_pat0", {29'b0, pat0}, 32'h6);
    gap(0);

    // 5: reset, eight 1s (second instance: 2-bit counter saturates)
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    for (int i = 0; i < 8; i++) bit_in(1);
    chk("t5_cnt1", {30'b0, cnt1}, 32'd3);
    gap(0);

    // 6: partial pattern killed by reset
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    bit_in(1); bit_in(0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
    chk("t6_cnt0", {24'b0, cnt0}, 32'd0);
    bit_in(1); bit_in(0); bit_in(1);
    chk("t6_y0", {31'b0, y0}, 32'd1);

    // all-zero pattern must not match zeroed history
    step(1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 1'b1);
    bit_in(0); bit_in(0);
    chk("zero_y0", {31'b0, y0}, 32'd0);
    bit_in(0);
    chk("zero_y0b", {31'b0, y0}, 32'd1);

    // randomized traffic, occasional loads and resets
    for (int i = 0; i < 600; i++) begin
      int unsigned sel;
      sel = $urandom_range(0, 99);
      if (sel < 2)       step(1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0);
      else if (sel < 7)  step(1'b0, 1'($urandom), 1'($urandom), 1'b1,
                              3'($urandom), 1'($urandom));
      else if (sel < 27) gap(1'($urandom));
      else               bit_in(1'($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
